// File: rtl/cam_capture.sv
// cam_capture: assembles RGB565 pixels from an 8-bit DVP camera bus with frame/line bookkeeping
// Ports: clk/reset (sync, active-high); enable sampled at frame start;
//        cam_vs/cam_hs/cam_d camera VSYNC, HREF and data byte (high byte first);
//        pix_valid/pix_data/pix_x/pix_y pixel strobe, value and coordinates;
//        sof/eol first-pixel and last-pixel-of-line flags; frame_done/frame_err end-of-frame pulses.
module cam_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cam_vs,
    input  logic        cam_hs,
    input  logic [7:0]  cam_d,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        sof,
    output logic        eol,
    output logic        frame_done,
    output logic        frame_err
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SOF = 2'd1;
    localparam logic [1:0] ACTIVE   = 2'd2;
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [8:0]  V_LIM = 9'(V_ACTIVE);

    logic [1:0]  state_q, state_d;
    logic        vs_q, hs_q, phase_q, phase_d, bad_q, bad_d;
    logic [7:0]  hi_q, hi_d;
    logic [10:0] cnt_q, cnt_d;
    logic [8:0]  y_q, y_d;
    logic [9:0]  x_q, x_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, done_q, done_d, err_q, err_d;
    logic        vs_rise, vs_fall, hs_fall;

    assign vs_rise = cam_vs & ~vs_q;
    assign vs_fall = ~cam_vs & vs_q;
    assign hs_fall = ~cam_hs & hs_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bad_d   = bad_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        x_d     = x_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (vs_rise) state_d = WAIT_SOF;
        end else if (state_q == WAIT_SOF) begin
            y_d     = '0;
            x_d     = '0;
            cnt_d   = '0;
            phase_d = 1'b0;
            if (vs_fall && enable) state_d = ACTIVE;
        end else if (vs_rise) begin
            // a line still open when VSYNC rises is truncated, so the frame cannot be complete
            done_d  = (y_q == V_LIM) && !bad_q && !hs_q;
            err_d   = !done_d;
            bad_d   = 1'b0;
            phase_d = 1'b0;
            cnt_d   = '0;
            state_d = WAIT_SOF;
        end else if (cam_hs) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = cam_d;
            end else begin
                // count saturates one past H_ACTIVE so overlong lines stay distinguishable
                cnt_d = (cnt_q > H_LIM) ? cnt_q : cnt_q + 11'd1;
                if (cnt_q >= H_LIM || y_q >= V_LIM) begin
                    bad_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    data_d  = {hi_q, cam_d};
                    x_d     = cnt_q[9:0];
                    sof_d   = (cnt_q == '0) && (y_q == '0);
                    eol_d   = (cnt_q == H_LIM - 11'd1);
                end
            end
        end else if (hs_fall) begin
            phase_d = 1'b0;
            cnt_d   = '0;
            x_d     = '0;
            if (phase_q || cnt_q != H_LIM) bad_d = 1'b1;
            if (cnt_q != '0 && y_q < V_LIM) y_d = y_q + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            phase_q <= 1'b0;
            bad_q   <= 1'b0;
            hi_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= cam_vs;
            hs_q    <= cam_hs;
            phase_q <= phase_d;
            bad_q   <= bad_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            x_q     <= x_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pix_valid  = valid_q;
    assign pix_data   = data_q;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
endmodule
